// File: rtl/mult_acc_pipe.sv
// Pipelined signed/unsigned multiplier-accumulator with valid/ready flow control.
// One global advance signal moves every stage together; bubbles travel as cleared valid bits.
module mult_acc_pipe #(
  parameter int ASIZE      = 15,
  parameter int BSIZE      = 11,
  parameter int PIPE_DEPTH = 2,
  parameter int ACC_SIZE   = 34
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ASIZE-1:0]    a,
  input  logic [BSIZE-1:0]    b,
  input  logic                a_signed,
  input  logic                b_signed,
  input  logic                acc_en,
  input  logic                acc_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_SIZE-1:0] p,
  output logic                ovf
);

  localparam int PSIZE = ASIZE + BSIZE + 1;
  localparam int NPS   = PIPE_DEPTH - 2;

  localparam logic [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
  localparam logic [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

  logic                adv;
  logic                out_valid_q, out_valid_d;
  logic [ACC_SIZE-1:0] p_q, p_d;
  logic                ovf_q, ovf_d;
  logic [ACC_SIZE-1:0] acc_q, acc_d;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign ovf       = ovf_q;

  // Stage 1: operands and sideband
  logic             s1_vld_q, s1_vld_d;
  logic [ASIZE-1:0] s1_a_q, s1_a_d;
  logic [BSIZE-1:0] s1_b_q, s1_b_d;
  logic             s1_as_q, s1_as_d;
  logic             s1_bs_q, s1_bs_d;
  logic             s1_en_q, s1_en_d;
  logic             s1_clr_q, s1_clr_d;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_as_d  = s1_as_q;
    s1_bs_d  = s1_bs_q;
    s1_en_d  = s1_en_q;
    s1_clr_d = s1_clr_q;
    if (adv) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_a_d   = a;
        s1_b_d   = b;
        s1_as_d  = a_signed;
        s1_bs_d  = b_signed;
        s1_en_d  = acc_en;
        s1_clr_d = acc_clr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_as_q  <= 1'b0;
      s1_bs_q  <= 1'b0;
      s1_en_q  <= 1'b0;
      s1_clr_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_as_q  <= s1_as_d;
      s1_bs_q  <= s1_bs_d;
      s1_en_q  <= s1_en_d;
      s1_clr_q <= s1_clr_d;
    end
  end

  // Both operands widened to PSIZE two's complement; the low PSIZE bits of the product are exact.
  logic [ASIZE:0]   a_ext;
  logic [BSIZE:0]   b_ext;
  logic [PSIZE-1:0] a_wide, b_wide, prod_s1;

  assign a_ext   = {s1_as_q & s1_a_q[ASIZE-1], s1_a_q};
  assign b_ext   = {s1_bs_q & s1_b_q[BSIZE-1], s1_b_q};
  assign a_wide  = {{(PSIZE-ASIZE-1){a_ext[ASIZE]}}, a_ext};
  assign b_wide  = {{(PSIZE-BSIZE-1){b_ext[BSIZE]}}, b_ext};
  assign prod_s1 = a_wide * b_wide;

  logic             fin_vld;
  logic [PSIZE-1:0] fin_prod;
  logic             fin_en;
  logic             fin_clr;

  generate
    if (NPS == 0) begin : g_direct
      assign fin_vld  = s1_vld_q;
      assign fin_prod = prod_s1;
      assign fin_en   = s1_en_q;
      assign fin_clr  = s1_clr_q;
    end else begin : g_prod_pipe
      logic [NPS-1:0]   ps_vld_q, ps_vld_d;
      logic [NPS-1:0]   ps_en_q, ps_en_d;
      logic [NPS-1:0]   ps_clr_q, ps_clr_d;
      logic [PSIZE-1:0] ps_prod_q [NPS];
      logic [PSIZE-1:0] ps_prod_d [NPS];

      always_comb begin
        ps_vld_d  = ps_vld_q;
        ps_en_d   = ps_en_q;
        ps_clr_d  = ps_clr_q;
        ps_prod_d = ps_prod_q;
        if (adv) begin
          ps_vld_d[0]  = s1_vld_q;
          ps_en_d[0]   = s1_en_q;
          ps_clr_d[0]  = s1_clr_q;
          ps_prod_d[0] = prod_s1;
          for (int k = 1; k < NPS; k++) begin
            ps_vld_d[k]  = ps_vld_q[k-1];
            ps_en_d[k]   = ps_en_q[k-1];
            ps_clr_d[k]  = ps_clr_q[k-1];
            ps_prod_d[k] = ps_prod_q[k-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ps_vld_q <= '0;
          ps_en_q  <= '0;
          ps_clr_q <= '0;
          for (int k = 0; k < NPS; k++) ps_prod_q[k] <= '0;
        end else begin
          ps_vld_q  <= ps_vld_d;
          ps_en_q   <= ps_en_d;
          ps_clr_q  <= ps_clr_d;
          ps_prod_q <= ps_prod_d;
        end
      end

      assign fin_vld  = ps_vld_q[NPS-1];
      assign fin_prod = ps_prod_q[NPS-1];
      assign fin_en   = ps_en_q[NPS-1];
      assign fin_clr  = ps_clr_q[NPS-1];
    end
  endgenerate

  // Final stage: one guard bit detects clipping of the accumulate sum.
  logic [ACC_SIZE-1:0] prod_ext, acc_base, acc_sat;
  logic [ACC_SIZE:0]   sum;
  logic                clip;

  assign prod_ext = {{(ACC_SIZE-PSIZE){fin_prod[PSIZE-1]}}, fin_prod};
  assign acc_base = fin_clr ? '0 : acc_q;
  assign sum      = {acc_base[ACC_SIZE-1], acc_base} + {prod_ext[ACC_SIZE-1], prod_ext};
  assign clip     = sum[ACC_SIZE] ^ sum[ACC_SIZE-1];
  assign acc_sat  = clip ? (sum[ACC_SIZE] ? ACC_MIN : ACC_MAX) : sum[ACC_SIZE-1:0];

  always_comb begin
    out_valid_d = out_valid_q;
    p_d         = p_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    if (adv) begin
      out_valid_d = fin_vld;
      if (fin_vld) begin
        if (fin_en) begin
          acc_d = acc_sat;
          p_d   = acc_sat;
          ovf_d = clip;
        end else begin
          p_d   = prod_ext;
          ovf_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Bench for mult_acc_pipe: two instances (depth 2 / 34-bit acc, depth 4 / 28-bit acc),
// directed vector tables, backpressure and reset sequences, and a randomized scoreboard run.
module tb_mult_acc_pipe;

  localparam int AW = 15;
  localparam int BW = 11;
  localparam int W0 = 34;
  localparam int W1 = 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          iv [2];
  logic          ir [2];
  logic [AW-1:0] a_i [2];
  logic [BW-1:0] b_i [2];
  logic          asg [2];
  logic          bsg [2];
  logic          en [2];
  logic          clr [2];
  logic          ov [2];
  logic          ordy [2];
  logic          of [2];
  logic [W0-1:0] p0;
  logic [W1-1:0] p1;

  mult_acc_pipe #(.ASIZE(AW), .BSIZE(BW), .PIPE_DEPTH(2), .ACC_SIZE(W0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_i[0]), .b(b_i[0]),
    .a_signed(asg[0]), .b_signed(bsg[0]), .acc_en(en[0]), .acc_clr(clr[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .p(p0), .ovf(of[0]));

  mult_acc_pipe #(.ASIZE(AW), .BSIZE(BW), .PIPE_DEPTH(4), .ACC_SIZE(W1)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_i[1]), .b(b_i[1]),
    .a_signed(asg[1]), .b_signed(bsg[1]), .acc_en(en[1]), .acc_clr(clr[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .p(p1), .ovf(of[1]));

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    bit            as;
    bit            bs;
    bit            en;
    bit            clr;
    longint        ep;
    bit            eo;
  } vec_t;

  typedef struct {
    longint p;
    bit     o;
  } exp_t;

  vec_t   tbl [$];
  vec_t   tbl_a [$];
  vec_t   tbl_sat [$];
  vec_t   tbl_post [$];
  vec_t   bp [8];
  exp_t   exp0 [$];
  exp_t   exp1 [$];
  longint macc [2];
  int     total = 0;
  int     bad = 0;

  function automatic vec_t mk(logic [AW-1:0] a, logic [BW-1:0] b, bit as, bit bs,
                              bit e, bit c, longint ep, bit eo);
    vec_t v;
    v.a = a; v.b = b; v.as = as; v.bs = bs; v.en = e; v.clr = c; v.ep = ep; v.eo = eo;
    return v;
  endfunction

  task automatic chk(string nm, longint act, longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic longint get_p(int d);
    if (d == 0) return longint'($signed(p0));
    return longint'($signed(p1));
  endfunction

  function automatic longint sx(longint v, int w, bit s);
    if (s && v[w-1]) return v - (longint'(1) << w);
    return v;
  endfunction

  // Reference: exact integer product, then optional saturating accumulate.
  task automatic model(int d, logic [AW-1:0] a, logic [BW-1:0] b, bit as, bit bs,
                       bit e, bit c, output longint ep, output bit eo);
    longint prod, sum, hi, lo;
    int w;
    w    = (d == 0) ? W0 : W1;
    prod = sx(longint'(a), AW, as) * sx(longint'(b), BW, bs);
    if (!e) begin
      ep = prod;
      eo = 1'b0;
    end else begin
      sum = (c ? 64'sd0 : macc[d]) + prod;
      hi  = (longint'(1) << (w - 1)) - 1;
      lo  = -(longint'(1) << (w - 1));
      if (sum > hi) begin ep = hi; eo = 1'b1; end
      else if (sum < lo) begin ep = lo; eo = 1'b1; end
      else begin ep = sum; eo = 1'b0; end
      macc[d] = ep;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int d, vec_t v);
    iv[d] = 1'b1; a_i[d] = v.a; b_i[d] = v.b; asg[d] = v.as; bsg[d] = v.bs;
    en[d] = v.en; clr[d] = v.clr;
  endtask

  task automatic run_table(int d);
    int lat, n;
    lat = (d == 0) ? 1 : 3;
    n   = tbl.size();
    ordy[d] = 1'b1;
    for (int i = 0; i < n + lat; i++) begin
      if (i < n) drive(d, tbl[i]);
      else iv[d] = 1'b0;
      tick();
      if (i < lat) chk($sformatf("tbl%0d_latency_vld", d), ov[d], 0);
      else begin
        chk($sformatf("tbl%0d[%0d]_vld", d, i - lat), ov[d], 1);
        chk($sformatf("tbl%0d[%0d]_p", d, i - lat), get_p(d), tbl[i-lat].ep);
        chk($sformatf("tbl%0d[%0d]_ovf", d, i - lat), of[d], tbl[i-lat].eo);
      end
    end
    tick();
    chk($sformatf("tbl%0d_drain_vld", d), ov[d], 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint ep;
    bit     eo;
    int     k, gotn;

    tbl_a.push_back(mk(15'h7FFF, 11'h7FF, 0, 0, 0, 0, 67074049, 0));
    tbl_a.push_back(mk(15'h7FFF, 11'h7FF, 1, 1, 0, 0, 1, 0));
    tbl_a.push_back(mk(15'h7FFF, 11'h7FF, 1, 0, 0, 0, -2047, 0));
    tbl_a.push_back(mk(15'd3, 11'd5, 0, 0, 1, 1, 15, 0));
    tbl_a.push_back(mk(15'd7, 11'd11, 0, 0, 1, 0, 92, 0));
    tbl_a.push_back(mk(15'd2, 11'd2, 0, 0, 1, 0, 96, 0));
    tbl_a.push_back(mk(15'd4, 11'd4, 0, 0, 0, 0, 16, 0));
    tbl_a.push_back(mk(15'd1, 11'd1, 0, 0, 1, 0, 97, 0));
    tbl_a.push_back(mk(15'h7FFF, 11'd3, 1, 0, 1, 0, 94, 0));
    tbl_a.push_back(mk(15'h4000, 11'h7FF, 1, 0, 0, 0, -33538048, 0));
    tbl_a.push_back(mk(15'h4000, 11'h400, 1, 1, 0, 0, 16777216, 0));
    tbl_a.push_back(mk(15'd0, 11'h7FF, 1, 1, 1, 0, 94, 0));
    tbl_a.push_back(mk(15'd5, 11'd5, 0, 0, 0, 1, 25, 0));
    tbl_a.push_back(mk(15'd1, 11'd1, 0, 0, 1, 0, 95, 0));

    tbl_sat.push_back(mk(15'h7FFF, 11'h7FF, 0, 0, 1, 1, 67074049, 0));
    tbl_sat.push_back(mk(15'h7FFF, 11'h7FF, 0, 0, 1, 0, 134148098, 0));
    tbl_sat.push_back(mk(15'h7FFF, 11'h7FF, 0, 0, 1, 0, 134217727, 1));
    tbl_sat.push_back(mk(15'h7FFF, 11'd1, 1, 1, 1, 0, 134217726, 0));
    tbl_sat.push_back(mk(15'h4000, 11'h7FF, 1, 0, 1, 1, -33538048, 0));
    tbl_sat.push_back(mk(15'h4000, 11'h7FF, 1, 0, 1, 0, -67076096, 0));
    tbl_sat.push_back(mk(15'h4000, 11'h7FF, 1, 0, 1, 0, -100614144, 0));
    tbl_sat.push_back(mk(15'h4000, 11'h7FF, 1, 0, 1, 0, -134152192, 0));
    tbl_sat.push_back(mk(15'h4000, 11'h7FF, 1, 0, 1, 0, -134217728, 1));
    tbl_sat.push_back(mk(15'h4000, 11'h400, 1, 1, 0, 0, 16777216, 0));
    tbl_sat.push_back(mk(15'd1, 11'd1, 0, 0, 1, 0, -134217727, 0));

    tbl_post.push_back(mk(15'd2, 11'd3, 0, 0, 1, 0, 6, 0));
    tbl_post.push_back(mk(15'd5, 11'd5, 0, 0, 1, 0, 31, 0));

    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; a_i[d] = '0; b_i[d] = '0; asg[d] = 0; bsg[d] = 0;
      en[d] = 0; clr[d] = 0; ordy[d] = 1; macc[d] = 0;
    end

    // Reset state
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_vld", d), ov[d], 0);
      chk($sformatf("rst%0d_p", d), get_p(d), 0);
      chk($sformatf("rst%0d_ovf", d), of[d], 0);
    end
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst0_in_ready", ir[0], 1);
    chk("rst1_in_ready", ir[1], 1);
    tick();

    tbl = tbl_a;
    run_table(0);
    tbl = tbl_sat;
    run_table(1);

    // Backpressure on the depth-4 instance: out_ready low for cycles 5..7
    for (int i = 0; i < 8; i++) begin
      bp[i] = mk(15'($urandom), 11'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 0);
      model(1, bp[i].a, bp[i].b, bp[i].as, bp[i].bs, 0, 0, ep, eo);
      bp[i].ep = ep;
    end
    k = 0;
    gotn = 0;
    for (int c = 0; c < 40 && gotn < 8; c++) begin
      ordy[1] = !(c >= 5 && c <= 7);
      if (k < 8) drive(1, bp[k]);
      else iv[1] = 1'b0;
      #1;
      chk($sformatf("bp_in_ready_c%0d", c), ir[1], (c >= 5 && c <= 7) ? 0 : 1);
      if (c >= 5 && c <= 7 && gotn < 8) begin
        chk($sformatf("bp_hold_vld_c%0d", c), ov[1], 1);
        chk($sformatf("bp_hold_p_c%0d", c), get_p(1), bp[gotn].ep);
      end
      if (ov[1] && ordy[1]) begin
        if (gotn < 8) begin
          chk($sformatf("bp_res%0d_p", gotn), get_p(1), bp[gotn].ep);
          chk($sformatf("bp_res%0d_ovf", gotn), of[1], 0);
        end
        gotn++;
      end
      if (iv[1] && ir[1]) k++;
      tick();
    end
    chk("bp_delivered", gotn, 8);
    chk("bp_sent", k, 8);
    iv[1] = 1'b0;
    ordy[1] = 1'b1;
    repeat (4) tick();
    chk("bp_no_dup_vld", ov[1], 0);

    // Reset in the middle of an accumulation stream
    drive(0, mk(15'd3, 11'd3, 0, 0, 1, 1, 0, 0));
    tick();
    drive(0, mk(15'd3, 11'd3, 0, 0, 1, 0, 0, 0));
    tick();
    chk("pre_rst_vld", ov[0], 1);
    chk("pre_rst_p", get_p(0), 9);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async_rst%0d_vld", d), ov[d], 0);
      chk($sformatf("async_rst%0d_p", d), get_p(d), 0);
      chk($sformatf("async_rst%0d_ovf", d), of[d], 0);
    end
    iv[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst0_in_ready", ir[0], 1);
    chk("post_rst1_in_ready", ir[1], 1);
    tick();
    tbl = tbl_post;
    run_table(0);

    // Randomized run against the reference model
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    macc[0] = 0;
    macc[1] = 0;
    tick();
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (c < 500) begin
          iv[d] = ($urandom % 4) != 0;
          case ($urandom % 4)
            0: a_i[d] = 15'h7FFF;
            1: a_i[d] = 15'h4000;
            default: a_i[d] = 15'($urandom);
          endcase
          case ($urandom % 4)
            0: b_i[d] = 11'h7FF;
            1: b_i[d] = 11'h400;
            default: b_i[d] = 11'($urandom);
          endcase
          asg[d] = 1'($urandom);
          bsg[d] = 1'($urandom);
          en[d]  = 1'($urandom);
          clr[d] = ($urandom % 5) == 0;
          ordy[d] = ($urandom % 4) != 0;
        end else begin
          iv[d] = 1'b0;
          ordy[d] = 1'b1;
        end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        if (iv[d] && ir[d]) begin
          model(d, a_i[d], b_i[d], asg[d], bsg[d], en[d], clr[d], ep, eo);
          e.p = ep;
          e.o = eo;
          if (d == 0) exp0.push_back(e);
          else exp1.push_back(e);
        end
        if (ov[d] && ordy[d]) begin
          if ((d == 0 && exp0.size() == 0) || (d == 1 && exp1.size() == 0)) begin
            chk($sformatf("rand%0d_unexpected_vld", d), ov[d], 0);
          end else begin
            e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
            chk($sformatf("rand%0d_p", d), get_p(d), e.p);
            chk($sformatf("rand%0d_ovf", d), of[d], e.o);
          end
        end
      end
      tick();
    end
    chk("rand0_left", exp0.size(), 0);
    chk("rand1_left", exp1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
